// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus arbiter: owner FSM states, the bundled bus
// request and the idle bus value.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        CPU_OWN,
        WAIT_BOUNDARY,
        TURN_TO_DMA,
        DMA_OWN,
        TURN_TO_CPU
    } arb_state_t;

    typedef enum logic [1:0] {
        SEL_CPU,
        SEL_DMA,
        SEL_NONE
    } bus_sel_t;

    typedef struct packed {
        logic        mem_rd;
        logic        mem_wr;
        logic        io_rd;
        logic        io_wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_req_t;

    localparam bus_req_t BUS_IDLE = '0;

    function automatic logic any_strobe(input bus_req_t r);
        return r.mem_rd | r.mem_wr | r.io_rd | r.io_wr;
    endfunction

endpackage

// File: rtl/z80_bus_arbiter_bus_mux.sv
// Owner select for the shared Z80 bus. In a turnaround no strobe is driven
// and address/data park on the values last presented by the previous owner.
module bus_mux
    import z80_bus_pkg::*;
(
    input  bus_sel_t    sel,
    input  logic        dma_ack,
    input  bus_req_t    cpu_bus,
    input  bus_req_t    dma_bus,
    input  logic [15:0] hold_addr,
    input  logic [7:0]  hold_wdata,
    output bus_req_t    bus_out
);

    bus_req_t dma_masked;

    always_comb begin
        dma_masked = dma_bus;
        if (!dma_ack) begin
            dma_masked.mem_rd = 1'b0;
            dma_masked.mem_wr = 1'b0;
            dma_masked.io_rd  = 1'b0;
            dma_masked.io_wr  = 1'b0;
        end

        bus_out       = BUS_IDLE;
        bus_out.addr  = hold_addr;
        bus_out.wdata = hold_wdata;
        case (sel)
            SEL_CPU: bus_out = cpu_bus;
            SEL_DMA: bus_out = dma_masked;
            default: ;
        endcase
    end

endmodule

// File: rtl/z80_bus_arbiter.sv
// BUSREQ/BUSACK arbiter sharing the Z80 bus between the CPU sequencer and one
// DMA master, granting only at CPU bus-cycle boundaries with a turnaround cycle.
module z80_bus_arbiter
    import z80_bus_pkg::*;
#(
    parameter int MAX_DMA_HOLD   = 256,
    parameter int MIN_CPU_WINDOW = 4,
    parameter int HOLD_W         = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_rd,
    input  logic        cpu_mem_wr,
    input  logic        cpu_io_rd,
    input  logic        cpu_io_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_cycle_done,
    output logic        cpu_hold,
    input  logic        dma_req,
    output logic        dma_ack,
    input  logic        dma_mem_rd,
    input  logic        dma_mem_wr,
    input  logic        dma_io_rd,
    input  logic        dma_io_wr,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        bus_mem_rd,
    output logic        bus_mem_wr,
    output logic        bus_io_rd,
    output logic        bus_io_wr,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        dma_err
);

    localparam int WIN_W = (MIN_CPU_WINDOW < 1) ? 1 : $clog2(MIN_CPU_WINDOW + 1);

    arb_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WIN_W-1:0]  window_cnt_q, window_cnt_d;
    logic              dma_ack_q, dma_ack_d;
    logic              dma_err_q, dma_err_d;
    logic [15:0]       addr_hold_q, addr_hold_d;
    logic [7:0]        wdata_hold_q, wdata_hold_d;

    bus_req_t cpu_bus, dma_bus, mux_out;
    bus_sel_t sel;
    logic     cpu_idle, window_zero, grant_ok, hold_limit;

    assign cpu_bus  = '{mem_rd: cpu_mem_rd, mem_wr: cpu_mem_wr, io_rd: cpu_io_rd,
                        io_wr: cpu_io_wr, addr: cpu_addr, wdata: cpu_wdata};
    assign dma_bus  = '{mem_rd: dma_mem_rd, mem_wr: dma_mem_wr, io_rd: dma_io_rd,
                        io_wr: dma_io_wr, addr: dma_addr, wdata: dma_wdata};

    assign cpu_idle    = !any_strobe(cpu_bus);
    assign window_zero = (window_cnt_q == '0);
    assign grant_ok    = dma_req && window_zero && (cpu_idle || cpu_cycle_done);
    assign hold_limit  = (MAX_DMA_HOLD != 0) &&
                         (hold_cnt_q == HOLD_W'(MAX_DMA_HOLD - 1));

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        window_cnt_d = window_cnt_q;
        cpu_hold     = 1'b0;
        sel          = SEL_CPU;

        case (state_q)
            CPU_OWN: begin
                if (!window_zero) begin
                    window_cnt_d = window_cnt_q - WIN_W'(1);
                end
                if (grant_ok) begin
                    state_d  = TURN_TO_DMA;
                    cpu_hold = 1'b1;
                end else if (dma_req && window_zero) begin
                    state_d = WAIT_BOUNDARY;
                end
            end
            WAIT_BOUNDARY: begin
                // A withdrawn request wins over a boundary arriving in the same cycle.
                if (!dma_req) begin
                    state_d = CPU_OWN;
                end else if (cpu_cycle_done || cpu_idle) begin
                    state_d  = TURN_TO_DMA;
                    cpu_hold = 1'b1;
                end
            end
            TURN_TO_DMA: begin
                sel        = SEL_NONE;
                cpu_hold   = 1'b1;
                hold_cnt_d = '0;
                state_d    = DMA_OWN;
            end
            DMA_OWN: begin
                sel        = SEL_DMA;
                cpu_hold   = 1'b1;
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (!dma_req || hold_limit) begin
                    state_d = TURN_TO_CPU;
                end
            end
            TURN_TO_CPU: begin
                sel          = SEL_NONE;
                cpu_hold     = 1'b1;
                window_cnt_d = WIN_W'(MIN_CPU_WINDOW);
                state_d      = CPU_OWN;
            end
            default: state_d = CPU_OWN;
        endcase

        dma_ack_d    = (state_d == DMA_OWN);
        dma_err_d    = dma_err_q | (!dma_ack_q && any_strobe(dma_bus));
        addr_hold_d  = mux_out.addr;
        wdata_hold_d = mux_out.wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CPU_OWN;
            hold_cnt_q   <= '0;
            window_cnt_q <= '0;
            dma_ack_q    <= 1'b0;
            dma_err_q    <= 1'b0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            window_cnt_q <= window_cnt_d;
            dma_ack_q    <= dma_ack_d;
            dma_err_q    <= dma_err_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    bus_mux u_bus_mux (
        .sel        (sel),
        .dma_ack    (dma_ack_q),
        .cpu_bus    (cpu_bus),
        .dma_bus    (dma_bus),
        .hold_addr  (addr_hold_q),
        .hold_wdata (wdata_hold_q),
        .bus_out    (mux_out)
    );

    assign bus_mem_rd = mux_out.mem_rd;
    assign bus_mem_wr = mux_out.mem_wr;
    assign bus_io_rd  = mux_out.io_rd;
    assign bus_io_wr  = mux_out.io_wr;
    assign bus_addr   = mux_out.addr;
    assign bus_wdata  = mux_out.wdata;
    assign dma_ack    = dma_ack_q;
    assign dma_err    = dma_err_q;

`ifdef FORMAL
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!((bus_mem_rd || bus_io_rd) && (bus_mem_wr || bus_io_wr)));
            assert (!((bus_mem_rd || bus_mem_wr) && (bus_io_rd || bus_io_wr)));
            assert (!dma_ack_q || state_q == DMA_OWN);
            assert (!(state_q == TURN_TO_DMA || state_q == TURN_TO_CPU) ||
                    !any_strobe(mux_out));
        end
    end
`endif

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter: expected bus snapshots are queued as
// stimulus is applied and compared against the DUT mid-cycle.
module tb_z80_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_mem_rd, cpu_mem_wr, cpu_io_rd, cpu_io_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_cycle_done;
    logic        cpu_hold;
    logic        dma_req;
    logic        dma_ack;
    logic        dma_mem_rd, dma_mem_wr, dma_io_rd, dma_io_wr;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        bus_mem_rd, bus_mem_wr, bus_io_rd, bus_io_wr;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        dma_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [30:0] exp;
    } exp_t;

    exp_t sb[$];

    z80_bus_arbiter #(
        .MAX_DMA_HOLD   (8),
        .MIN_CPU_WINDOW (4),
        .HOLD_W         (9)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_mem_rd     (cpu_mem_rd),
        .cpu_mem_wr     (cpu_mem_wr),
        .cpu_io_rd      (cpu_io_rd),
        .cpu_io_wr      (cpu_io_wr),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_cycle_done (cpu_cycle_done),
        .cpu_hold       (cpu_hold),
        .dma_req        (dma_req),
        .dma_ack        (dma_ack),
        .dma_mem_rd     (dma_mem_rd),
        .dma_mem_wr     (dma_mem_wr),
        .dma_io_rd      (dma_io_rd),
        .dma_io_wr      (dma_io_wr),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .bus_mem_rd     (bus_mem_rd),
        .bus_mem_wr     (bus_mem_wr),
        .bus_io_rd      (bus_io_rd),
        .bus_io_wr      (bus_io_wr),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .dma_err        (dma_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot layout: {dma_ack, cpu_hold, dma_err, {mem_rd,mem_wr,io_rd,io_wr}, addr, wdata}
    function automatic logic [30:0] snap(input logic ack, input logic hold,
                                         input logic err, input logic [3:0] strb,
                                         input logic [15:0] addr, input logic [7:0] wd);
        return {ack, hold, err, strb, addr, wd};
    endfunction

    task automatic check(input string tag, input logic [30:0] exp);
        exp_t        e;
        logic [30:0] obs;
        sb.push_back('{tag, exp});
        @(negedge clk);
        e   = sb.pop_front();
        obs = {dma_ack, cpu_hold, dma_err, bus_mem_rd, bus_mem_wr, bus_io_rd,
               bus_io_wr, bus_addr, bus_wdata};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
        $display("check %-12s obs=%h exp=%h", e.tag, obs, e.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {cpu_mem_rd, cpu_mem_wr, cpu_io_rd, cpu_io_wr} = 4'b0000;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_cycle_done = 1'b0;
        dma_req = 1'b0;
        {dma_mem_rd, dma_mem_wr, dma_io_rd, dma_io_wr} = 4'b0000;
        dma_addr = 16'h0000; dma_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset", snap(0, 0, 0, 4'b0000, 16'h0000, 8'h00));

        // CPU memory read owns the bus
        reset = 1'b0;
        cpu_mem_rd = 1'b1; cpu_addr = 16'h1234;
        check("cpu_rd", snap(0, 0, 0, 4'b1000, 16'h1234, 8'h00));

        // DMA request mid CPU cycle waits for the boundary
        dma_req = 1'b1;
        check("req_mid", snap(0, 0, 0, 4'b1000, 16'h1234, 8'h00));
        check("wait_bnd", snap(0, 0, 0, 4'b1000, 16'h1234, 8'h00));
        cpu_cycle_done = 1'b1;
        check("boundary", snap(0, 1, 0, 4'b1000, 16'h1234, 8'h00));

        cpu_cycle_done = 1'b0; cpu_mem_rd = 1'b0;
        check("turn_dma", snap(0, 1, 0, 4'b0000, 16'h1234, 8'h00));

        // Five DMA writes, request withdrawn with the last one
        dma_mem_wr = 1'b1; dma_wdata = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            dma_addr = 16'h8000 + 16'(i);
            if (i == 4) dma_req = 1'b0;
            check($sformatf("dma_wr%0d", i),
                  snap(1, 1, 0, 4'b0100, 16'h8000 + 16'(i), 8'hAA));
        end

        // Release turnaround; request re-asserted straight away
        dma_mem_wr = 1'b0; dma_req = 1'b1;
        check("turn_cpu", snap(0, 1, 0, 4'b0000, 16'h8004, 8'hAA));

        cpu_addr = 16'h2000; cpu_wdata = 8'h55;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("window%0d", i), snap(0, 0, 0, 4'b0000, 16'h2000, 8'h55));
        end
        check("regrant", snap(0, 1, 0, 4'b0000, 16'h2000, 8'h55));
        check("turn_dma2", snap(0, 1, 0, 4'b0000, 16'h2000, 8'h55));

        // Request held high: forced release after MAX_DMA_HOLD cycles
        dma_mem_rd = 1'b1; dma_addr = 16'h9000;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("dma_hold%0d", i), snap(1, 1, 0, 4'b1000, 16'h9000, 8'hAA));
        end
        dma_mem_rd = 1'b0;
        check("forced_rel", snap(0, 1, 0, 4'b0000, 16'h9000, 8'hAA));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("window2_%0d", i), snap(0, 0, 0, 4'b0000, 16'h2000, 8'h55));
        end
        check("regrant2", snap(0, 1, 0, 4'b0000, 16'h2000, 8'h55));
        check("turn_dma3", snap(0, 1, 0, 4'b0000, 16'h2000, 8'h55));
        dma_mem_rd = 1'b1; dma_addr = 16'h9100;
        check("dma3", snap(1, 1, 0, 4'b1000, 16'h9100, 8'hAA));

        // Reset in the middle of DMA ownership
        reset = 1'b1; dma_req = 1'b0; dma_mem_rd = 1'b0;
        cpu_mem_rd = 1'b1; cpu_addr = 16'h3000;
        check("rst_in_dma", snap(1, 1, 0, 4'b0000, 16'h9100, 8'hAA));
        check("rst_cpu", snap(0, 0, 0, 4'b1000, 16'h3000, 8'h55));

        // DMA strobe without BUSACK: masked, flags a sticky error
        reset = 1'b0; dma_io_wr = 1'b1;
        check("err_mask", snap(0, 0, 0, 4'b1000, 16'h3000, 8'h55));
        dma_io_wr = 1'b0;
        check("err_set", snap(0, 0, 1, 4'b1000, 16'h3000, 8'h55));
        cpu_addr = 16'h3001; reset = 1'b1;
        check("err_sticky", snap(0, 0, 1, 4'b1000, 16'h3001, 8'h55));
        check("err_clr", snap(0, 0, 0, 4'b1000, 16'h3001, 8'h55));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_bus_arbiter.md
Name: z80_bus_arbiter

Overview:
Shares the single Z80 memory/IO bus between the CPU sequencer and one external DMA master, with BUSREQ/BUSACK semantics. The DMA master is granted the bus only at a CPU bus-cycle boundary. The CPU is stalled while the DMA master owns the bus. A one-cycle turnaround separates every change of owner. Sits between sequencer and the top-level bus strobes/address/data in z80.

Parameters:
MAX_DMA_HOLD, 256, max consecutive DMA_OWN cycles before forced release; 0 = unlimited
MIN_CPU_WINDOW, 4, cycles the CPU keeps the bus after a DMA release before a new grant
HOLD_W, 9, width of hold counter (>= clog2(MAX_DMA_HOLD+1))

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_mem_rd / cpu_mem_wr / cpu_io_rd / cpu_io_wr  in  1 each  sequencer strobes
cpu_addr  in  16  sequencer address
cpu_wdata  in  8  sequencer write data
cpu_cycle_done  in  1  sequencer completes its current bus cycle this clock
cpu_hold  out  1  sequencer must not start a new bus cycle while high
dma_req  in  1  DMA bus request (BUSREQ)
dma_ack  out  1  DMA owns bus (BUSACK), registered
dma_mem_rd / dma_mem_wr / dma_io_rd / dma_io_wr  in  1 each  DMA strobes
dma_addr  in  16  DMA address
dma_wdata  in  8  DMA write data
bus_mem_rd / bus_mem_wr / bus_io_rd / bus_io_wr  out  1 each  muxed strobes to pins
bus_addr  out  16  muxed address
bus_wdata  out  8  muxed write data
dma_err  out  1  sticky: DMA strobe seen while dma_ack low

Behaviour:
- States: CPU_OWN, WAIT_BOUNDARY, TURN_TO_DMA, DMA_OWN, TURN_TO_CPU.
- Reset: state CPU_OWN; dma_ack=0; cpu_hold=0; dma_err=0; hold_cnt=0; window_cnt=0. Reset mid-DMA returns the bus to the CPU on the next cycle.
- cpu_idle = no cpu strobe active.
- grant_ok = dma_req && window_cnt==0 && (cpu_idle || cpu_cycle_done).
- CPU_OWN:
  - window_cnt decrements to 0.
  - If grant_ok, go to TURN_TO_DMA.
  - Else if dma_req && window_cnt==0, go to WAIT_BOUNDARY.
- WAIT_BOUNDARY:
  - If cpu_cycle_done || cpu_idle, go to TURN_TO_DMA.
  - If dma_req drops, return to CPU_OWN.
- TURN_TO_DMA: all bus strobes 0; hold_cnt cleared. Next state DMA_OWN.
- DMA_OWN:
  - dma_ack=1; bus outputs mirror dma inputs; hold_cnt++ each cycle.
  - Go to TURN_TO_CPU when !dma_req, or when MAX_DMA_HOLD!=0 && hold_cnt==MAX_DMA_HOLD-1.
  - dma_ack drops on entry to TURN_TO_CPU.
- TURN_TO_CPU: all bus strobes 0; load window_cnt=MIN_CPU_WINDOW. Next state CPU_OWN.
- cpu_hold is combinational, so the sequencer sees it at the same edge where it would begin a new cycle. It is 1 when:
  - state is TURN_TO_DMA, DMA_OWN or TURN_TO_CPU; or
  - state is CPU_OWN or WAIT_BOUNDARY and the transition to TURN_TO_DMA fires this cycle.
- Muxing:
  - CPU_OWN and WAIT_BOUNDARY: bus = cpu inputs.
  - Turnaround states: strobes 0; addr/wdata hold the last owner's values.
  - DMA strobes are masked whenever dma_ack=0.
- dma_err sets on any dma strobe while dma_ack=0. Cleared only by reset.
- dma_req re-asserted in TURN_TO_CPU is not granted until window_cnt reaches 0.
- Bus cycle minimum: a DMA grant costs 2 turnaround cycles plus DMA_OWN cycles.
- Invariants (assert under FORMAL):
  - bus rd/wr never both high; mem and io never both active.
  - dma_ack implies state DMA_OWN.
  - bus strobes 0 in turnaround states.

Decomposition:
- Shared package z80_bus_pkg:
  - arb_state_t enum.
  - bus_req_t struct (mem_rd, mem_wr, io_rd, io_wr, addr[15:0], wdata[7:0]).
  - BUS_IDLE constant.
- Sub-module bus_mux: combinational owner select plus masking of two bus_req_t inputs.
- FSM and counters stay in z80_bus_arbiter.

Test Plan:
- Reset, CPU mem_rd at 0x1234 -> bus_addr=0x1234, bus_mem_rd=1, dma_ack=0, cpu_hold=0.
- dma_req raised mid CPU read; cpu_cycle_done 2 cycles later -> cpu_hold=1 that cycle, 1 turnaround cycle with strobes 0, then dma_ack=1 and DMA mem_wr 0x8000/0xAA appears on the bus.
- dma_req dropped after 5 DMA cycles -> dma_ack=0 next cycle, 1 turnaround, CPU_OWN. Immediate dma_req re-assert is not granted for 4 cycles (MIN_CPU_WINDOW).
- MAX_DMA_HOLD=8 with dma_req held high -> dma_ack high exactly 8 cycles, forced release, re-grant after window + turnaround.
- DMA strobe asserted before dma_ack -> bus strobes stay CPU-driven, dma_err=1 and sticky until reset.
- Reset asserted during DMA_OWN -> next cycle dma_ack=0, cpu_hold=0, state CPU_OWN, counters 0.
